// File: rtl/ctrl_defs.sv
// Shared encodings for the multi-cycle MIPS control path: states, ALUOp, mux selects, opcodes, functs.
package ctrl_defs;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_LOAD_WB   = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_I_EXEC    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_JR        = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    // ALUOp codes, expanded by the ALU-control decoder
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_SLT   = 3'b100;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_RS    = 2'b01;
    localparam logic [1:0] SA_SHAMT = 2'b10;

    localparam logic [1:0] SB_RT      = 2'b00;
    localparam logic [1:0] SB_FOUR    = 2'b01;
    localparam logic [1:0] SB_IMM     = 2'b10;
    localparam logic [1:0] SB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PS_ALU    = 2'b00;
    localparam logic [1:0] PS_ALUOUT = 2'b01;
    localparam logic [1:0] PS_JUMP   = 2'b10;
    localparam logic [1:0] PS_RS     = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    // Shifts take their A operand from the shamt field instead of rs
    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

endpackage

// File: rtl/multicycle_dispatch.sv
// Decodes OpCode/Funct into the state that follows DECODE; flags unsupported encodings.
// Latency: purely combinational.
// Backpressure: none, stateless.
module multicycle_dispatch
    import ctrl_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output state_t     next_state,
    output logic       illegal
);

    always_comb begin
        next_state = S_TRAP;
        unique case (opcode)
            OP_LW, OP_SW:  next_state = S_MEM_ADDR;
            OP_BEQ:        next_state = S_BRANCH;
            OP_J, OP_JAL:  next_state = S_JUMP;
            OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_SLTI, OP_SLTIU, OP_LUI:
                           next_state = S_I_EXEC;
            OP_RTYPE: begin
                if (funct == FN_JR || funct == FN_JALR)
                    next_state = S_JR;
                else if (funct inside {[6'h20:6'h27], 6'h2a, 6'h2b, FN_SLL, FN_SRL, FN_SRA})
                    next_state = S_R_EXEC;
            end
            default:       next_state = S_TRAP;
        endcase
    end

    assign illegal = (next_state == S_TRAP);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS core; sequences fetch/decode/execute/mem/writeback.
// Latency: 3-5 cycles per instruction plus one cycle per MemReady=0 in a memory state.
// Backpressure: holds FETCH/MEM_READ/MEM_WRITE with strobes steady until MemReady.
module multicycle_control
    import ctrl_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             ExtOp,
    output logic             LuiOp,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       RegDst,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [2:0]       ALUOp,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstCount
);

    state_t state, next_state, dispatch_state;
    logic   dispatch_illegal;
    logic   retire;

    // Zero is consumed by the datapath's PC write-enable gate, not by this FSM
    logic unused_zero;
    assign unused_zero = Zero;

    multicycle_dispatch u_dispatch (
        .opcode     (OpCode),
        .funct      (Funct),
        .next_state (dispatch_state),
        .illegal    (dispatch_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            InstCount <= '0;
        end else begin
            state <= next_state;
            if (retire)
                InstCount <= InstCount + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_FETCH:     if (MemReady) next_state = S_DECODE;
            S_DECODE:    next_state = dispatch_illegal ? S_TRAP : dispatch_state;
            S_MEM_ADDR:  next_state = (OpCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (MemReady) next_state = S_LOAD_WB;
            S_MEM_WRITE: if (MemReady) begin
                             next_state = S_FETCH;
                             retire     = 1'b1;
                         end
            S_R_EXEC,
            S_I_EXEC:    next_state = S_ALU_WB;
            S_LOAD_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JR: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            default:     next_state = S_FETCH;
        endcase
    end

    // Reset gates the decode so nothing strobes while FETCH is being forced
    always_comb begin
        PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
        MemWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; ExtOp = 1'b0;
        LuiOp = 1'b0; Illegal = 1'b0;
        MemtoReg = M2R_ALUOUT; RegDst = RD_RT; ALUSrcA = SA_PC;
        ALUSrcB = SB_RT; PCSource = PS_ALU; ALUOp = ALUOP_ADD;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SB_FOUR;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                S_DECODE:   ALUSrcB = SB_IMM_SH2;
                S_MEM_ADDR: begin
                    ALUSrcA = SA_RS;
                    ALUSrcB = SB_IMM;
                    ExtOp   = 1'b1;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_LOAD_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = M2R_MDR;
                end
                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_R_EXEC: begin
                    ALUSrcA = is_shift(Funct) ? SA_SHAMT : SA_RS;
                    ALUOp   = ALUOP_RTYPE;
                end
                S_ALU_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = (OpCode == OP_RTYPE) ? RD_RD : RD_RT;
                end
                S_I_EXEC: begin
                    ALUSrcA = SA_RS;
                    ALUSrcB = SB_IMM;
                    ExtOp   = (OpCode != OP_ANDI);
                    LuiOp   = (OpCode == OP_LUI);
                    if (OpCode == OP_ANDI)
                        ALUOp = ALUOP_AND;
                    else if (OpCode == OP_SLTI || OpCode == OP_SLTIU)
                        ALUOp = ALUOP_SLT;
                end
                S_BRANCH: begin
                    ALUSrcA     = SA_RS;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PS_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PS_JUMP;
                    if (OpCode == OP_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RA;
                        MemtoReg = M2R_PC;
                    end
                end
                S_JR: begin
                    PCWrite  = 1'b1;
                    PCSource = PS_RS;
                    if (Funct == FN_JALR) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RD;
                        MemtoReg = M2R_PC;
                    end
                end
                S_TRAP:  Illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control words checked against hand-derived values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
    logic       Zero, MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic       ExtOp, LuiOp, Illegal;
    logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] InstCount;

    int n_chk  = 0;
    int n_pass = 0;

    multicycle_control #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ExtOp(ExtOp), .LuiOp(LuiOp), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .Illegal(Illegal), .InstCount(InstCount)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [22:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                  ExtOp, LuiOp, Illegal, MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp};

    function automatic logic [22:0] cw(
        input logic pw, pwc, iord, mr, mw, irw, rw, ext, lui, ill,
        input logic [1:0] m2r, rdst, sa, sb, ps,
        input logic [2:0] aop);
        return {pw, pwc, iord, mr, mw, irw, rw, ext, lui, ill, m2r, rdst, sa, sb, ps, aop};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drive MemReady, check this cycle's control word, then advance one clock
    task automatic step(input logic mrdy, input logic [22:0] exp, input string tag);
        MemReady = mrdy;
        #1;
        chk(tag, {9'b0, obs}, {9'b0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        OpCode = op;
        Funct  = fn;
    endtask

    logic [22:0] F0, F1, DEC, MADDR, MRD, LWB, MWR, RADD, RSLL, AWBR, AWBI;
    logic [22:0] IANDI, ISLTI, BR, JAL, JMP, JALR, TRP;

    initial begin
        F0    = cw(0,0,0,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b01,2'b00,3'b000);
        F1    = cw(1,0,0,1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b01,2'b00,3'b000);
        DEC   = cw(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11,2'b00,3'b000);
        MADDR = cw(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b01,2'b10,2'b00,3'b000);
        MRD   = cw(0,0,1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000);
        LWB   = cw(0,0,0,0,0,0,1,0,0,0, 2'b01,2'b00,2'b00,2'b00,2'b00,3'b000);
        MWR   = cw(0,0,1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000);
        RADD  = cw(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00,3'b010);
        RSLL  = cw(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10,2'b00,2'b00,3'b010);
        AWBR  = cw(0,0,0,0,0,0,1,0,0,0, 2'b00,2'b01,2'b00,2'b00,2'b00,3'b000);
        AWBI  = cw(0,0,0,0,0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000);
        IANDI = cw(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b10,2'b00,3'b011);
        ISLTI = cw(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b01,2'b10,2'b00,3'b100);
        BR    = cw(0,1,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b01,3'b001);
        JAL   = cw(1,0,0,0,0,0,1,0,0,0, 2'b10,2'b10,2'b00,2'b00,2'b10,3'b000);
        JMP   = cw(1,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b10,3'b000);
        JALR  = cw(1,0,0,0,0,0,1,0,0,0, 2'b10,2'b01,2'b00,2'b00,2'b11,3'b000);
        TRP   = cw(0,0,0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000);

        reset = 1'b0; MemReady = 1'b1; Zero = 1'b0;
        instr(6'h00, 6'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {9'b0, obs}, 32'h0);
        chk("reset_count", {28'b0, InstCount}, 32'h0);
        reset = 1'b1;

        // lw with two wait cycles in FETCH and in MEM_READ: 9 cycles
        instr(6'h23, 6'h00);
        step(0, F0, "lw_fetch_wait0");
        step(0, F0, "lw_fetch_wait1");
        step(1, F1, "lw_fetch");
        step(0, DEC, "lw_decode");
        step(0, MADDR, "lw_memaddr");
        step(0, MRD, "lw_memread_wait0");
        step(0, MRD, "lw_memread_wait1");
        step(1, MRD, "lw_memread");
        chk("lw_count_before", {28'b0, InstCount}, 32'd0);
        step(0, LWB, "lw_loadwb");
        chk("lw_count_after", {28'b0, InstCount}, 32'd1);

        instr(6'h00, 6'h20);
        step(1, F1, "add_fetch");
        step(1, DEC, "add_decode");
        step(1, RADD, "add_rexec");
        step(1, AWBR, "add_aluwb");

        instr(6'h00, 6'h00);
        step(1, F1, "sll_fetch");
        step(1, DEC, "sll_decode");
        step(1, RSLL, "sll_rexec");
        step(1, AWBR, "sll_aluwb");
        chk("count_after_r", {28'b0, InstCount}, 32'd3);

        instr(6'h04, 6'h00);
        Zero = 1'b1;
        step(1, F1, "beq_fetch");
        step(1, DEC, "beq_decode");
        step(1, BR, "beq_branch");
        Zero = 1'b0;

        instr(6'h03, 6'h00);
        step(1, F1, "jal_fetch_after_beq");
        step(1, DEC, "jal_decode");
        step(1, JAL, "jal_jump");

        instr(6'h00, 6'h09);
        step(1, F1, "jalr_fetch");
        step(1, DEC, "jalr_decode");
        step(1, JALR, "jalr_jr");
        chk("count_after_jumps", {28'b0, InstCount}, 32'd6);

        instr(6'h0c, 6'h00);
        step(1, F1, "andi_fetch");
        step(1, DEC, "andi_decode");
        step(1, IANDI, "andi_iexec");
        step(1, AWBI, "andi_aluwb");

        instr(6'h0a, 6'h00);
        step(1, F1, "slti_fetch");
        step(1, DEC, "slti_decode");
        step(1, ISLTI, "slti_iexec");
        step(1, AWBI, "slti_aluwb");

        instr(6'h3f, 6'h00);
        step(1, F1, "trap_fetch");
        step(1, DEC, "trap_decode");
        step(1, TRP, "trap_illegal");
        step(0, F0, "trap_pulse_ended");
        chk("trap_count_unchanged", {28'b0, InstCount}, 32'd8);

        // sw aborted by reset during the MEM_WRITE wait
        instr(6'h2b, 6'h00);
        step(1, F1, "sw_fetch");
        step(1, DEC, "sw_decode");
        step(0, MADDR, "sw_memaddr");
        step(0, MWR, "sw_memwrite_wait0");
        MemReady = 1'b0;
        #1;
        chk("sw_memwrite_wait1", {9'b0, obs}, {9'b0, MWR});
        reset = 1'b0;
        #1;
        chk("abort_outputs", {9'b0, obs}, 32'h0);
        chk("abort_count", {28'b0, InstCount}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_held", {9'b0, obs}, 32'h0);
        reset = 1'b1;
        step(0, F0, "release_fetch");
        chk("release_count", {28'b0, InstCount}, 32'd0);

        step(1, F1, "sw_fetch2");
        step(1, DEC, "sw_decode2");
        step(1, MADDR, "sw_memaddr2");
        step(1, MWR, "sw_memwrite2");
        chk("sw_count", {28'b0, InstCount}, 32'd1);

        // 14 jumps reach all-ones, the 15th wraps to zero
        instr(6'h02, 6'h00);
        for (int i = 0; i < 14; i++) begin
            step(1, F1, "j_fetch");
            step(1, DEC, "j_decode");
            step(1, JMP, "j_jump");
        end
        chk("count_all_ones", {28'b0, InstCount}, 32'd15);
        step(1, F1, "j_fetch_last");
        step(1, DEC, "j_decode_last");
        step(1, JMP, "j_jump_last");
        chk("count_wrap", {28'b0, InstCount}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
